// File: rtl/fight_pkg.sv
// Shared types and constants for the combat stage: attack FSM states,
// key codes and player body geometry.
package fight_pkg;

   typedef enum logic [1:0] {
      ATK_IDLE    = 2'd0,
      ATK_WINDUP  = 2'd1,
      ATK_ACTIVE  = 2'd2,
      ATK_RECOVER = 2'd3
   } atk_state_t;

   localparam logic [7:0]  P1_ATK_KEY   = 8'h09;
   localparam logic [7:0]  P2_ATK_KEY   = 8'h12;
   localparam logic [7:0]  P1_GUARD_KEY = 8'h16;
   localparam logic [7:0]  P2_GUARD_KEY = 8'h0E;

   localparam logic [10:0] P1_W     = 11'd120;
   localparam logic [10:0] P2_W     = 11'd105;
   localparam logic [10:0] PLAYER_H = 11'd180;

   function automatic logic key_down(input logic [7:0] k0, input logic [7:0] k1,
                                     input logic [7:0] k2, input logic [7:0] k3,
                                     input logic [7:0] key);
      return (k0 == key) || (k1 == key) || (k2 == key) || (k3 == key);
   endfunction

   // Half-open interval intersection: [a_lo,a_hi) vs [b_lo,b_hi).
   function automatic logic span_overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                         input logic [10:0] b_lo, input logic [10:0] b_hi);
      return (a_lo < b_hi) && (b_lo < a_hi);
   endfunction

endpackage

// File: rtl/attack_fsm.sv
// Per-player attack sequencer: key edge detect, WINDUP/ACTIVE/RECOVER timing
// and the one-hit-per-attack flag.
module attack_fsm
   import fight_pkg::*;
#(
   parameter int WINDUP_FRAMES  = 6,
   parameter int ACTIVE_FRAMES  = 4,
   parameter int RECOVER_FRAMES = 10
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       i_key,
   input  logic       i_interrupt,
   input  logic       i_freeze,
   input  logic       i_hit_landed,
   output atk_state_t o_state,
   output logic       o_active_unhit
);

   atk_state_t r_state;
   logic [7:0] r_count;
   logic       r_hit_done;
   logic       r_key_q;
   logic       r_key_prev;
   logic       w_key_edge;

   // Edge comes from registered samples, giving one frame of start latency.
   assign w_key_edge     = r_key_q & ~r_key_prev;
   assign o_state        = r_state;
   assign o_active_unhit = (r_state == ATK_ACTIVE) && !r_hit_done;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_state    <= ATK_IDLE;
         r_count    <= 8'd0;
         r_hit_done <= 1'b0;
         r_key_q    <= 1'b0;
         r_key_prev <= 1'b0;
      end else begin
         r_key_q    <= i_key;
         r_key_prev <= r_key_q;
         if (i_hit_landed)
            r_hit_done <= 1'b1;
         if (i_freeze) begin
            r_state <= ATK_IDLE;
            r_count <= 8'd0;
         end else begin
            case (r_state)
               ATK_IDLE: if (w_key_edge) begin
                  r_state    <= ATK_WINDUP;
                  r_count    <= 8'(WINDUP_FRAMES - 1);
                  r_hit_done <= 1'b0;
               end
               ATK_WINDUP: if (i_interrupt) begin
                  r_state <= ATK_IDLE;
                  r_count <= 8'd0;
               end else if (r_count == 8'd0) begin
                  r_state <= ATK_ACTIVE;
                  r_count <= 8'(ACTIVE_FRAMES - 1);
               end else begin
                  r_count <= r_count - 8'd1;
               end
               ATK_ACTIVE: if (r_count == 8'd0) begin
                  r_state <= ATK_RECOVER;
                  r_count <= 8'(RECOVER_FRAMES - 1);
               end else begin
                  r_count <= r_count - 8'd1;
               end
               default: if (r_count == 8'd0) begin
                  r_state <= ATK_IDLE;
               end else begin
                  r_count <= r_count - 8'd1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/fight_resolver.sv
// Combat resolver: hitbox tests, health, KO and winner for two players.
// Optional guarding (reduced damage, no interrupt) enabled by FIGHT_BLOCK_EN.
module fight_resolver
   import fight_pkg::*;
#(
   parameter logic [7:0] START_HEALTH   = 8'd100,
   parameter logic [7:0] DAMAGE         = 8'd10,
   parameter int         WINDUP_FRAMES  = 6,
   parameter int         ACTIVE_FRAMES  = 4,
   parameter int         RECOVER_FRAMES = 10,
   parameter int         REACH          = 30
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode_0,
   input  logic [7:0] keycode_1,
   input  logic [7:0] keycode_2,
   input  logic [7:0] keycode_3,
   input  logic [9:0] Player1X,
   input  logic [9:0] Player1Y,
   input  logic [9:0] Player2X,
   input  logic [9:0] Player2Y,
   output logic [7:0] P1Health,
   output logic [7:0] P2Health,
   output logic [1:0] P1AtkState,
   output logic [1:0] P2AtkState,
   output logic       P1Hit,
   output logic       P2Hit,
   output logic       KO,
   output logic [1:0] Winner
);

   localparam logic [10:0] W_REACH = 11'(REACH);

   logic [7:0] r_p1_health, r_p2_health;
   logic       r_p1_hit, r_p2_hit, r_ko;
   logic [1:0] r_winner;

   atk_state_t w_p1_state, w_p2_state;
   logic       w_p1_active_unhit, w_p2_active_unhit;
   logic       w_p1_key, w_p2_key, w_p1_guarded, w_p2_guarded;
   logic       w_p1_strikes, w_p2_strikes, w_freeze, w_ko_now;
   logic [10:0] w_p1_x, w_p1_y, w_p2_x, w_p2_y;
   logic [10:0] w_p1_hb_lo, w_p1_hb_hi, w_p2_hb_lo, w_p2_hb_hi;
   logic [7:0] w_dmg_to_p1, w_dmg_to_p2, w_p1_health_next, w_p2_health_next;
   logic       w_y_overlap;

   assign w_p1_x = {1'b0, Player1X};
   assign w_p1_y = {1'b0, Player1Y};
   assign w_p2_x = {1'b0, Player2X};
   assign w_p2_y = {1'b0, Player2Y};

   assign w_p1_key = key_down(keycode_0, keycode_1, keycode_2, keycode_3, P1_ATK_KEY);
   assign w_p2_key = key_down(keycode_0, keycode_1, keycode_2, keycode_3, P2_ATK_KEY);

`ifdef FIGHT_BLOCK_EN
   assign w_p1_guarded = (w_p1_state == ATK_IDLE) &&
                         key_down(keycode_0, keycode_1, keycode_2, keycode_3, P1_GUARD_KEY);
   assign w_p2_guarded = (w_p2_state == ATK_IDLE) &&
                         key_down(keycode_0, keycode_1, keycode_2, keycode_3, P2_GUARD_KEY);
`else
   assign w_p1_guarded = 1'b0;
   assign w_p2_guarded = 1'b0;
`endif

   // Ties in X face right; the left hitbox clamps at column 0.
   assign w_p1_hb_lo = (w_p1_x <= w_p2_x) ? w_p1_x + P1_W
                     : ((w_p1_x >= W_REACH) ? w_p1_x - W_REACH : 11'd0);
   assign w_p1_hb_hi = (w_p1_x <= w_p2_x) ? w_p1_x + P1_W + W_REACH : w_p1_x;
   assign w_p2_hb_lo = (w_p2_x <= w_p1_x) ? w_p2_x + P2_W
                     : ((w_p2_x >= W_REACH) ? w_p2_x - W_REACH : 11'd0);
   assign w_p2_hb_hi = (w_p2_x <= w_p1_x) ? w_p2_x + P2_W + W_REACH : w_p2_x;

   assign w_y_overlap = span_overlap(w_p1_y, w_p1_y + PLAYER_H, w_p2_y, w_p2_y + PLAYER_H);

   assign w_p1_strikes = w_p1_active_unhit && !r_ko && w_y_overlap &&
                         span_overlap(w_p1_hb_lo, w_p1_hb_hi, w_p2_x, w_p2_x + P2_W);
   assign w_p2_strikes = w_p2_active_unhit && !r_ko && w_y_overlap &&
                         span_overlap(w_p2_hb_lo, w_p2_hb_hi, w_p1_x, w_p1_x + P1_W);

   assign w_dmg_to_p1 = w_p1_guarded ? (DAMAGE >> 2) : DAMAGE;
   assign w_dmg_to_p2 = w_p2_guarded ? (DAMAGE >> 2) : DAMAGE;

   assign w_p1_health_next = !w_p2_strikes ? r_p1_health
                           : ((r_p1_health > w_dmg_to_p1) ? r_p1_health - w_dmg_to_p1 : 8'd0);
   assign w_p2_health_next = !w_p1_strikes ? r_p2_health
                           : ((r_p2_health > w_dmg_to_p2) ? r_p2_health - w_dmg_to_p2 : 8'd0);

   // Freezing on the KO edge itself sends both FSMs to IDLE with the KO flag.
   assign w_ko_now = !r_ko && ((w_p1_health_next == 8'd0) || (w_p2_health_next == 8'd0));
   assign w_freeze = r_ko || w_ko_now;

   attack_fsm #(
      .WINDUP_FRAMES (WINDUP_FRAMES),
      .ACTIVE_FRAMES (ACTIVE_FRAMES),
      .RECOVER_FRAMES(RECOVER_FRAMES)
   ) u_p1_fsm (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .i_key         (w_p1_key),
      .i_interrupt   (w_p2_strikes && !w_p1_guarded),
      .i_freeze      (w_freeze),
      .i_hit_landed  (w_p1_strikes),
      .o_state       (w_p1_state),
      .o_active_unhit(w_p1_active_unhit)
   );

   attack_fsm #(
      .WINDUP_FRAMES (WINDUP_FRAMES),
      .ACTIVE_FRAMES (ACTIVE_FRAMES),
      .RECOVER_FRAMES(RECOVER_FRAMES)
   ) u_p2_fsm (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .i_key         (w_p2_key),
      .i_interrupt   (w_p1_strikes && !w_p2_guarded),
      .i_freeze      (w_freeze),
      .i_hit_landed  (w_p2_strikes),
      .o_state       (w_p2_state),
      .o_active_unhit(w_p2_active_unhit)
   );

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_p1_health <= START_HEALTH;
         r_p2_health <= START_HEALTH;
         r_p1_hit    <= 1'b0;
         r_p2_hit    <= 1'b0;
         r_ko        <= 1'b0;
         r_winner    <= 2'd0;
      end else begin
         r_p1_health <= w_p1_health_next;
         r_p2_health <= w_p2_health_next;
         r_p1_hit    <= w_p2_strikes;
         r_p2_hit    <= w_p1_strikes;
         if (w_ko_now) begin
            r_ko     <= 1'b1;
            r_winner <= {w_p1_health_next == 8'd0, w_p2_health_next == 8'd0};
         end
      end
   end

   assign P1Health   = r_p1_health;
   assign P2Health   = r_p2_health;
   assign P1AtkState = w_p1_state;
   assign P2AtkState = w_p2_state;
   assign P1Hit      = r_p1_hit;
   assign P2Hit      = r_p2_hit;
   assign KO         = r_ko;
   assign Winner     = r_winner;

endmodule

// File: tb/tb_fight_resolver.sv
// Self-checking bench for fight_resolver: scenario table plus hand-written
// timing, interrupt, reset, KO and draw sequences.
module tb_fight_resolver;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] keycode_0 = 8'h00, keycode_1 = 8'h00, keycode_2 = 8'h00, keycode_3 = 8'h00;
   logic [9:0] Player1X = 10'd40, Player1Y = 10'd220, Player2X = 10'd480, Player2Y = 10'd220;
   logic [7:0] P1Health, P2Health;
   logic [1:0] P1AtkState, P2AtkState, Winner;
   logic       P1Hit, P2Hit, KO;

   int checks = 0;
   int errors = 0;

`ifdef FIGHT_BLOCK_EN
   localparam int GUARD_H = 98;
`else
   localparam int GUARD_H = 90;
`endif

   fight_resolver dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .keycode_0 (keycode_0),
      .keycode_1 (keycode_1),
      .keycode_2 (keycode_2),
      .keycode_3 (keycode_3),
      .Player1X  (Player1X),
      .Player1Y  (Player1Y),
      .Player2X  (Player2X),
      .Player2Y  (Player2Y),
      .P1Health  (P1Health),
      .P2Health  (P2Health),
      .P1AtkState(P1AtkState),
      .P2AtkState(P2AtkState),
      .P1Hit     (P1Hit),
      .P2Hit     (P2Hit),
      .KO        (KO),
      .Winner    (Winner)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      string name;
      int    x1, y1, x2, y2;
      bit    p1, p2, g2;
      int    h1, h2, n1, n2, nboth;
   } vec_t;

   typedef struct {
      string name;
      int    h1, h2, n1, n2, nboth;
   } exp_t;

   vec_t vecs[13];
   exp_t sb[$];

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic frame();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic drive_keys(input bit p1, input bit p2, input bit g2);
      keycode_0 = p1 ? 8'h09 : 8'h00;
      keycode_1 = 8'h00;
      keycode_2 = p2 ? 8'h12 : 8'h00;
      keycode_3 = g2 ? 8'h0E : 8'h00;
   endtask

   task automatic place(input int x1, input int y1, input int x2, input int y2);
      Player1X = 10'(x1);
      Player1Y = 10'(y1);
      Player2X = 10'(x2);
      Player2Y = 10'(y2);
   endtask

   task automatic do_reset();
      drive_keys(0, 0, 0);
      Reset = 1'b1;
      repeat (2) frame();
      Reset = 1'b0;
      frame();
   endtask

   // One-frame tap, then run and count Hit pulses and non-IDLE frames.
   task automatic tap_and_run(input bit p1, input bit p2, input bit g2, input int frames,
                              output int n1, output int n2, output int nboth, output int busy);
      n1 = 0; n2 = 0; nboth = 0; busy = 0;
      drive_keys(p1, p2, g2);
      frame();
      drive_keys(0, 0, g2);
      repeat (frames) begin
         frame();
         n1 += int'(P1Hit);
         n2 += int'(P2Hit);
         nboth += int'(P1Hit & P2Hit);
         busy += int'(P1AtkState != 2'd0 || P2AtkState != 2'd0);
      end
      drive_keys(0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n1, n2, nb, busy;
      exp_t e;

      vecs[0]  = '{"miss_far",     40, 220, 480, 220, 1, 0, 0, 100, 100,     0, 0, 0};
      vecs[1]  = '{"p1_hit_right", 40, 220, 170, 220, 1, 0, 0, 100, 90,      0, 1, 0};
      vecs[2]  = '{"mutual",       40, 220, 170, 220, 1, 1, 0, 90,  90,      1, 1, 1};
      vecs[3]  = '{"p2_hit_left",  40, 220, 170, 220, 0, 1, 0, 90,  100,     1, 0, 0};
      vecs[4]  = '{"p1_face_left", 300, 220, 170, 220, 1, 0, 0, 100, 90,     0, 1, 0};
      vecs[5]  = '{"x_edge_miss",  40, 220, 190, 220, 1, 0, 0, 100, 100,     0, 0, 0};
      vecs[6]  = '{"x_edge_hit",   40, 220, 189, 220, 1, 0, 0, 100, 90,      0, 1, 0};
      vecs[7]  = '{"y_edge_miss",  40, 220, 170, 400, 1, 0, 0, 100, 100,     0, 0, 0};
      vecs[8]  = '{"y_edge_hit",   40, 220, 170, 399, 1, 0, 0, 100, 90,      0, 1, 0};
      vecs[9]  = '{"left_clamp",   10, 220, 0,   220, 1, 0, 0, 100, 90,      0, 1, 0};
      vecs[10] = '{"guard",        40, 220, 170, 220, 1, 0, 1, 100, GUARD_H, 0, 1, 0};
      vecs[11] = '{"p2_face_right", 170, 220, 40, 220, 0, 1, 0, 90, 100,     1, 0, 0};
      vecs[12] = '{"equal_x",      100, 220, 100, 220, 1, 0, 0, 100, 100,    0, 0, 0};

      // Reset state
      place(40, 220, 480, 220);
      do_reset();
      check("reset_p1health", int'(P1Health), 100);
      check("reset_p2health", int'(P2Health), 100);
      check("reset_p1state", int'(P1AtkState), 0);
      check("reset_p2state", int'(P2AtkState), 0);
      check("reset_hits", int'({P1Hit, P2Hit}), 0);
      check("reset_ko", int'(KO), 0);
      check("reset_winner", int'(Winner), 0);

      // Scenario table
      for (int i = 0; i < 13; i++) begin
         place(vecs[i].x1, vecs[i].y1, vecs[i].x2, vecs[i].y2);
         do_reset();
         sb.push_back('{vecs[i].name, vecs[i].h1, vecs[i].h2, vecs[i].n1, vecs[i].n2, vecs[i].nboth});
         tap_and_run(vecs[i].p1, vecs[i].p2, vecs[i].g2, 30, n1, n2, nb, busy);
         e = sb.pop_front();
         check({e.name, "_p1health"}, int'(P1Health), e.h1);
         check({e.name, "_p2health"}, int'(P2Health), e.h2);
         check({e.name, "_p1hits"}, n1, e.n1);
         check({e.name, "_p2hits"}, n2, e.n2);
         check({e.name, "_bothhits"}, nb, e.nboth);
         check({e.name, "_idle_end"}, int'({P1AtkState, P2AtkState}), 0);
         $display("vector %0s: P1Health=%0d P2Health=%0d P1Hit#=%0d P2Hit#=%0d",
                  e.name, P1Health, P2Health, n1, n2);
      end

      // Phase timing of a single attack that lands
      place(40, 220, 170, 220);
      do_reset();
      drive_keys(1, 0, 0);
      frame();
      check("timing_latency", int'(P1AtkState), 0);
      drive_keys(0, 0, 0);
      for (int s = 0; s <= 20; s++) begin
         frame();
         check($sformatf("timing_state_%0d", s), int'(P1AtkState),
               (s < 6) ? 1 : (s < 10) ? 2 : (s < 20) ? 3 : 0);
         check($sformatf("timing_p2hit_%0d", s), int'(P2Hit), (s == 7) ? 1 : 0);
         if (s == 6 || s == 7)
            check($sformatf("timing_p2health_%0d", s), int'(P2Health), (s == 7) ? 90 : 100);
      end
      $display("sequence timing: P2Health=%0d", P2Health);

      // Held key starts exactly one attack
      do_reset();
      drive_keys(1, 0, 0);
      repeat (45) frame();
      check("held_state", int'(P1AtkState), 0);
      check("held_p2health", int'(P2Health), 90);
      drive_keys(0, 0, 0);
      $display("sequence held key: P2Health=%0d", P2Health);

      // P2 interrupted during WINDUP
      do_reset();
      drive_keys(1, 0, 0);
      frame();
      drive_keys(0, 0, 0);
      frame();
      frame();
      drive_keys(0, 1, 0);
      frame();
      drive_keys(0, 0, 0);
      frame();
      check("intr_p2_windup", int'(P2AtkState), 1);
      repeat (4) frame();
      check("intr_p2_state", int'(P2AtkState), 0);
      check("intr_p2hit", int'(P2Hit), 1);
      check("intr_p2health", int'(P2Health), 90);
      repeat (25) frame();
      check("intr_p1health", int'(P1Health), 100);
      $display("sequence interrupt: P1Health=%0d P2Health=%0d", P1Health, P2Health);

      // Reset asserted mid-attack acts without a clock edge
      drive_keys(1, 0, 0);
      frame();
      drive_keys(0, 0, 0);
      repeat (3) frame();
      check("midrst_windup", int'(P1AtkState), 1);
      Reset = 1'b1;
      #1;
      check("midrst_state", int'(P1AtkState), 0);
      check("midrst_p2health", int'(P2Health), 100);
      frame();
      Reset = 1'b0;
      frame();
      $display("sequence mid-attack reset: P1AtkState=%0d P2Health=%0d", P1AtkState, P2Health);

      // KO with P1 winning, then frozen until Reset
      do_reset();
      for (int k = 0; k < 9; k++)
         tap_and_run(1, 0, 0, 24, n1, n2, nb, busy);
      check("ko_pre_p2health", int'(P2Health), 10);
      check("ko_pre_ko", int'(KO), 0);
      tap_and_run(1, 0, 0, 24, n1, n2, nb, busy);
      check("ko_p2health", int'(P2Health), 0);
      check("ko_flag", int'(KO), 1);
      check("ko_winner", int'(Winner), 1);
      check("ko_p2hits", n2, 1);
      tap_and_run(1, 1, 0, 30, n1, n2, nb, busy);
      check("frozen_busy", busy, 0);
      check("frozen_hits", n1 + n2, 0);
      check("frozen_p1health", int'(P1Health), 100);
      check("frozen_p2health", int'(P2Health), 0);
      check("frozen_ko", int'(KO), 1);
      check("frozen_winner", int'(Winner), 1);
      $display("sequence KO: P2Health=%0d KO=%0d Winner=%0d", P2Health, KO, Winner);
      do_reset();
      check("ko_reset_ko", int'(KO), 0);
      check("ko_reset_winner", int'(Winner), 0);
      check("ko_reset_p2health", int'(P2Health), 100);

      // Draw: both reach 0 on the same frame
      for (int k = 0; k < 10; k++)
         tap_and_run(1, 1, 0, 24, n1, n2, nb, busy);
      check("draw_p1health", int'(P1Health), 0);
      check("draw_p2health", int'(P2Health), 0);
      check("draw_ko", int'(KO), 1);
      check("draw_winner", int'(Winner), 3);
      $display("sequence draw: KO=%0d Winner=%0d", KO, Winner);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
